mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of flow_cpu; consumes the EXE-stage output bundle via a valid/allowin pipeline handshake.
//  Issues loads/stores to the data SRAM port (req/ready, variable-latency resp), aligns and extends load data.
//  Flags misaligned accesses and hands a single-entry result to WB.
// PARAMETERS
//  ADDR_W  32  data address width
//  DATA_W  32  data/register width (only 32 supported)
//  REG_W   5   register index width
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  rst             in   1       reset, synchronous, active-low
//  exe_valid       in   1       EXE bundle valid
//  mem_allowin     out  1       stage can accept a bundle this cycle
//  exe_pc          in   ADDR_W  instruction PC
//  exe_alu_res     in   DATA_W  ALU result / effective address
//  exe_store_data  in   DATA_W  rt value for stores
//  exe_mem_op      in   4       0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW (9-15 = none)
//  exe_wen         in   1       register write enable
//  exe_wdest       in   REG_W   destination register
//  dreq_valid      out  1       data SRAM request valid
//  dreq_ready      in   1       SRAM accepts request
//  dreq_wr         out  1       1 store, 0 load
//  dreq_addr       out  ADDR_W  byte address (= alu_res)
//  dreq_wstrb      out  4       byte write strobes
//  dreq_wdata      out  DATA_W  lane-replicated store data
//  dresp_valid     in   1       load data returned
//  dresp_rdata     in   DATA_W  raw word read
//  mem_valid       out  1       result valid to WB
//  wb_allowin      in   1       WB accepts result
//  mem_pc          out  ADDR_W  PC of held instruction
//  mem_wen         out  1       register write enable (0 if mem_ade)
//  mem_wdest       out  REG_W   destination register
//  mem_wdata       out  DATA_W  loaded data or alu_res
//  mem_ade         out  1       address error (misaligned)
// BEHAVIOUR
//  FSM states: IDLE, REQ, WAIT, DONE. Reset (rst==0 at edge): IDLE; all registered outputs 0; mem_allowin=1.
//  mem_allowin = (state==IDLE) | (state==DONE & wb_allowin) (combinational).
//  Accept on exe_valid & mem_allowin: latch bundle, then:
//   - mem_op none -> DONE, mem_wdata=alu_res.
//   - misaligned (LH/LHU/SH addr[0]; LW/SW addr[1:0]!=0) -> DONE, mem_ade=1, mem_wen=0, no SRAM request.
//   - else -> REQ.
//  Accept in DONE without exe_valid -> IDLE when wb_allowin.
//  REQ: dreq_valid=1, addr/wr/wstrb/wdata stable until dreq_ready. On handshake: store -> DONE (no response expected);
//   load -> WAIT.
//  WAIT: on dresp_valid capture aligned data -> DONE. dresp_valid in any other state is ignored.
//  DONE: mem_valid=1, outputs stable until wb_allowin; back-to-back accept allowed same cycle.
//  Strobes: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111. wdata: SB {4{b}}, SH {2{h}}, SW word.
//  Loads: byte/half selected by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  Latency (accept in cycle N): non-mem/ade -> mem_valid in N+1;
//   store, ready=1 -> dreq_valid N+1, mem_valid N+2;
//   load, ready=1, resp at N+2 -> mem_valid N+3.
//  Reset mid-operation aborts: dreq_valid drops next cycle, late response discarded, no mem_valid.
// TESTING
//  ALU op: exe_mem_op=0, alu_res=0x1234 -> mem_valid at N+1, mem_wdata=0x1234, no dreq_valid.
//  LB at 0x103, rdata=0x80FF_0000 -> mem_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080; LH at 0x102 -> 0xFFFF_80FF.
//  SH at 0x202, data=0xABCD1234 -> dreq_wstrb=4'b1100, dreq_wdata=0x12341234, dreq_wr=1.
//   Hold dreq_ready=0 3 cycles -> request fields stable; mem_allowin=0.
//  LW at 0x101 -> mem_ade=1, mem_wen=0, dreq_valid never asserted, mem_valid at N+1.
//  Back-to-back loads with wb_allowin=0 for 2 cycles in DONE -> outputs held;
//   next bundle accepted only in the cycle wb_allowin=1.
//  rst=0 in WAIT, then dresp_valid=1 after release -> stays IDLE, mem_valid=0, response ignored.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of flow_cpu.
//
// Accepts one EXE bundle at a time over a valid/allowin handshake, issues the
// load or store to the data SRAM port (req/ready, variable-latency response),
// aligns and sign/zero-extends load data, flags misaligned accesses, and holds
// a single result for WB until WB accepts it.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   exe_*               incoming EXE bundle (valid, pc, alu_res, store data,
//                       mem op, write enable, destination)
//   mem_allowin         stage can take a bundle this cycle (combinational)
//   dreq_*              data SRAM request (valid/ready, wr, addr, wstrb, wdata)
//   dresp_*             data SRAM load response (valid, raw word)
//   mem_valid/wb_allowin result handshake to WB
//   mem_pc/wen/wdest/wdata/ade  held result bundle
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    output logic              mem_allowin,
    input  logic [ADDR_W-1:0] exe_pc,
    input  logic [DATA_W-1:0] exe_alu_res,
    input  logic [DATA_W-1:0] exe_store_data,
    input  logic [3:0]        exe_mem_op,
    input  logic              exe_wen,
    input  logic [REG_W-1:0]  exe_wdest,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic              dreq_wr,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [3:0]        dreq_wstrb,
    output logic [DATA_W-1:0] dreq_wdata,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_rdata,
    output logic              mem_valid,
    input  logic              wb_allowin,
    output logic [ADDR_W-1:0] mem_pc,
    output logic              mem_wen,
    output logic [REG_W-1:0]  mem_wdest,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ade
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e     state;
    logic [3:0] op_q;   // op of the held instruction, needed to align load data

    // Decode of the incoming bundle, used only on the accept edge.
    logic        in_load;
    logic        in_store;
    logic        in_misaligned;
    logic [3:0]  in_wstrb;
    logic [31:0] in_wdata;
    logic        accept;

    assign mem_allowin = (state == IDLE) || (state == DONE && wb_allowin);
    assign accept      = exe_valid && mem_allowin;

    assign in_load  = (exe_mem_op >= OP_LB) && (exe_mem_op <= OP_LW);
    assign in_store = (exe_mem_op >= OP_SB) && (exe_mem_op <= OP_SW);

    always_comb begin
        in_misaligned = 1'b0;
        in_wstrb      = 4'b0000;
        in_wdata      = exe_store_data;
        case (exe_mem_op)
            OP_LH, OP_LHU: in_misaligned = exe_alu_res[0];
            OP_LW:         in_misaligned = exe_alu_res[1:0] != 2'b00;
            OP_SB: begin
                in_wstrb = 4'b0001 << exe_alu_res[1:0];
                in_wdata = {4{exe_store_data[7:0]}};
            end
            OP_SH: begin
                in_misaligned = exe_alu_res[0];
                in_wstrb      = 4'b0011 << {exe_alu_res[1], 1'b0};
                in_wdata      = {2{exe_store_data[15:0]}};
            end
            OP_SW: begin
                in_misaligned = exe_alu_res[1:0] != 2'b00;
                in_wstrb      = 4'b1111;
            end
            default: ;
        endcase
    end

    // Select the addressed byte/half of the raw word and extend it.
    function automatic logic [31:0] load_align(input logic [3:0] op,
                                               input logic [1:0] a,
                                               input logic [31:0] w);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = w >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   load_align = {{24{b[7]}}, b};
            OP_LBU:  load_align = {24'd0, b};
            OP_LH:   load_align = {{16{h[15]}}, h};
            OP_LHU:  load_align = {16'd0, h};
            default: load_align = w;
        endcase
    endfunction

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            op_q       <= 4'd0;
            dreq_valid <= 1'b0;
            dreq_wr    <= 1'b0;
            dreq_addr  <= '0;
            dreq_wstrb <= 4'b0000;
            dreq_wdata <= '0;
            mem_valid  <= 1'b0;
            mem_pc     <= '0;
            mem_wen    <= 1'b0;
            mem_wdest  <= '0;
            mem_wdata  <= '0;
            mem_ade    <= 1'b0;
        end else if (accept) begin
            op_q       <= exe_mem_op;
            mem_pc     <= exe_pc;
            mem_wdest  <= exe_wdest;
            mem_wen    <= exe_wen && !in_misaligned;
            mem_ade    <= in_misaligned;
            mem_wdata  <= exe_alu_res;
            dreq_wr    <= in_store;
            dreq_addr  <= exe_alu_res;
            dreq_wstrb <= in_wstrb;
            dreq_wdata <= in_wdata;
            if ((in_load || in_store) && !in_misaligned) begin
                state      <= REQ;
                dreq_valid <= 1'b1;
                mem_valid  <= 1'b0;
            end else begin
                // No SRAM access needed: result is ready next cycle.
                state      <= DONE;
                dreq_valid <= 1'b0;
                mem_valid  <= 1'b1;
            end
        end else begin
            case (state)
                REQ: if (dreq_ready) begin
                    dreq_valid <= 1'b0;
                    if (dreq_wr) begin
                        state     <= DONE;
                        mem_valid <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (dresp_valid) begin
                    mem_wdata <= load_align(op_q, dreq_addr[1:0], dresp_rdata);
                    state     <= DONE;
                    mem_valid <= 1'b1;
                end
                DONE: if (wb_allowin) begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage. Inputs are driven and outputs sampled
// 1 ns after each rising edge; combinational outputs are sampled after a
// further 1 ns settle.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid;
    logic        mem_allowin;
    logic [31:0] exe_pc;
    logic [31:0] exe_alu_res;
    logic [31:0] exe_store_data;
    logic [3:0]  exe_mem_op;
    logic        exe_wen;
    logic [4:0]  exe_wdest;
    logic        dreq_valid;
    logic        dreq_ready;
    logic        dreq_wr;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_wstrb;
    logic [31:0] dreq_wdata;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;
    logic        mem_valid;
    logic        wb_allowin;
    logic [31:0] mem_pc;
    logic        mem_wen;
    logic [4:0]  mem_wdest;
    logic [31:0] mem_wdata;
    logic        mem_ade;

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .mem_allowin(mem_allowin),
        .exe_pc(exe_pc), .exe_alu_res(exe_alu_res), .exe_store_data(exe_store_data),
        .exe_mem_op(exe_mem_op), .exe_wen(exe_wen), .exe_wdest(exe_wdest),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_wr(dreq_wr),
        .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .mem_valid(mem_valid), .wb_allowin(wb_allowin),
        .mem_pc(mem_pc), .mem_wen(mem_wen), .mem_wdest(mem_wdest),
        .mem_wdata(mem_wdata), .mem_ade(mem_ade)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [3:0] op,
                           input logic wen, input logic [4:0] wd);
        exe_valid      = 1'b1;
        exe_pc         = pc;
        exe_alu_res    = alu;
        exe_store_data = sd;
        exe_mem_op     = op;
        exe_wen        = wen;
        exe_wdest      = wd;
    endtask

    // Load with ready=1 and response two cycles after accept.
    task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        wb_allowin = 1'b1;
        dreq_ready = 1'b1;
        present(32'h0000_4000, addr, 32'd0, op, 1'b1, 5'd3);
        step();                                 // N+1: REQ
        exe_valid = 1'b0;
        check({tag, "_req"}, {30'd0, dreq_valid, dreq_wr}, 32'h2);
        step();                                 // N+2: WAIT
        check({tag, "_wait_valid"}, {31'd0, mem_valid}, 32'd0);
        dresp_valid = 1'b1;
        dresp_rdata = rdata;
        step();                                 // N+3: DONE
        dresp_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
        check({tag, "_wdata"}, mem_wdata, exp);
        step();                                 // back to IDLE
    endtask

    initial begin
        rst = 1'b0;
        exe_valid = 1'b0; exe_pc = '0; exe_alu_res = '0; exe_store_data = '0;
        exe_mem_op = '0; exe_wen = 1'b0; exe_wdest = '0;
        dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_rdata = '0; wb_allowin = 1'b1;
        step();
        step();
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
        check("rst_allowin", {31'd0, mem_allowin}, 32'd1);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        step();

        // ALU op: result next cycle, no SRAM request.
        present(32'h0000_1000, 32'h0000_1234, 32'd0, 4'd0, 1'b1, 5'd7);
        step();
        exe_valid = 1'b0;
        check("alu_valid", {31'd0, mem_valid}, 32'd1);
        check("alu_wdata", mem_wdata, 32'h0000_1234);
        check("alu_no_req", {31'd0, dreq_valid}, 32'd0);
        check("alu_wdest", {27'd0, mem_wdest}, 32'd7);
        check("alu_pc", mem_pc, 32'h0000_1000);
        step();
        check("alu_retire", {31'd0, mem_valid}, 32'd0);

        // Load alignment and extension.
        do_load("lb",  4'd1, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu", 4'd2, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
        do_load("lh",  4'd3, 32'h0000_0102, 32'h80FF_0000, 32'hFFFF_80FF);
        do_load("lhu", 4'd4, 32'h0000_0100, 32'h1234_8001, 32'h0000_8001);
        do_load("lb1", 4'd1, 32'h0000_0101, 32'h1234_5678, 32'h0000_0056);

        // SH with ready held low for 3 cycles.
        dreq_ready = 1'b0;
        present(32'h0000_2000, 32'h0000_0202, 32'hABCD_1234, 4'd7, 1'b0, 5'd0);
        step();
        exe_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sh_dreq_valid", {31'd0, dreq_valid}, 32'd1);
            check("sh_wr", {31'd0, dreq_wr}, 32'd1);
            check("sh_addr", dreq_addr, 32'h0000_0202);
            check("sh_wstrb", {28'd0, dreq_wstrb}, 32'hC);
            check("sh_wdata", dreq_wdata, 32'h1234_1234);
            check("sh_allowin", {31'd0, mem_allowin}, 32'd0);
            step();
        end
        dreq_ready = 1'b1;
        step();
        check("sh_done", {30'd0, mem_valid, dreq_valid}, 32'h2);
        step();

        // SB with ready=1: dreq_valid at N+1, mem_valid at N+2.
        present(32'h0000_2100, 32'h0000_0301, 32'h0000_005A, 4'd6, 1'b0, 5'd0);
        step();
        exe_valid = 1'b0;
        check("sb_req", {30'd0, mem_valid, dreq_valid}, 32'h1);
        check("sb_wstrb", {28'd0, dreq_wstrb}, 32'h2);
        check("sb_wdata", dreq_wdata, 32'h5A5A_5A5A);
        step();
        check("sb_done", {30'd0, mem_valid, dreq_valid}, 32'h2);
        step();

        // Misaligned LW: address error, no request, result next cycle.
        present(32'h0000_3000, 32'h0000_0101, 32'd0, 4'd5, 1'b1, 5'd9);
        step();
        exe_valid = 1'b0;
        check("ade_valid", {31'd0, mem_valid}, 32'd1);
        check("ade_flag", {31'd0, mem_ade}, 32'd1);
        check("ade_wen", {31'd0, mem_wen}, 32'd0);
        check("ade_no_req", {31'd0, dreq_valid}, 32'd0);
        step();
        check("ade_no_req2", {31'd0, dreq_valid}, 32'd0);

        // Back-to-back: first load stalls in DONE while WB is blocked.
        wb_allowin = 1'b0;
        dreq_ready = 1'b1;
        present(32'h0000_5000, 32'h0000_0100, 32'd0, 4'd5, 1'b1, 5'd4);
        step();
        exe_valid = 1'b0;
        step();
        dresp_valid = 1'b1;
        dresp_rdata = 32'h1122_3344;
        step();
        dresp_valid = 1'b0;
        present(32'h0000_5004, 32'h0000_0101, 32'd0, 4'd2, 1'b1, 5'd5);
        #1;
        check("b2b_allowin_blocked", {31'd0, mem_allowin}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("b2b_hold_valid", {31'd0, mem_valid}, 32'd1);
            check("b2b_hold_wdata", mem_wdata, 32'h1122_3344);
            check("b2b_hold_pc", mem_pc, 32'h0000_5000);
        end
        wb_allowin = 1'b1;
        #1;
        check("b2b_allowin_open", {31'd0, mem_allowin}, 32'd1);
        step();
        exe_valid = 1'b0;
        check("b2b_second_req", {30'd0, mem_valid, dreq_valid}, 32'h1);
        check("b2b_second_addr", dreq_addr, 32'h0000_0101);
        check("b2b_second_pc", mem_pc, 32'h0000_5004);
        step();
        dresp_valid = 1'b1;
        dresp_rdata = 32'hAABB_CCDD;
        step();
        dresp_valid = 1'b0;
        check("b2b_second_wdata", mem_wdata, 32'h0000_00CC);
        step();

        // Reset while waiting for load data; late response is discarded.
        present(32'h0000_6000, 32'h0000_0104, 32'd0, 4'd5, 1'b1, 5'd6);
        step();
        exe_valid = 1'b0;
        step();                                 // WAIT
        rst = 1'b0;
        step();
        rst = 1'b1;
        dresp_valid = 1'b1;
        dresp_rdata = 32'hDEAD_BEEF;
        #1;
        check("abort_allowin", {31'd0, mem_allowin}, 32'd1);
        check("abort_dreq", {31'd0, dreq_valid}, 32'd0);
        step();
        dresp_valid = 1'b0;
        check("abort_no_valid", {31'd0, mem_valid}, 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        step();
        check("abort_idle", {30'd0, mem_valid, mem_allowin}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
